alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin controller that shares the single combinational 32-bit ALU between two requesters, e.g. the main pipeline EX stage and a secondary address/branch unit. Each port submits an ALU operation through a valid/ready handshake. The arbiter latches the operands, drives the ALU for one execute cycle and captures the result and overflow. It then holds the response on the owning port until that port accepts it. It also supplies a defined result for opcodes the ALU does not implement.

## Interface
Parameters:
- DW, 32, data width of operands and result (ALU is fixed at 32)
- OPW, 4, ALU control opcode width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  port N (N=0,1) has an operation pending
- reqN_ready  out  1  port N operation accepted this cycle (valid&ready)
- reqN_op  in  OPW  ALU opcode
- reqN_x, reqN_y  in  DW  operands (signed)
- reqN_shamt  in  5  shift amount
- rspN_valid  out  1  result available for port N
- rspN_ready  in  1  port N consumes the result
- rspN_z  out  DW  result
- rspN_ovf  out  1  signed overflow flag of that operation
- alu_op  out  OPW  to ALU op
- alu_x, alu_y  out  DW  to ALU operands
- alu_shamt  out  5  to ALU shift amount
- alu_z  in  DW  from ALU result
- alu_overflow  in  1  from ALU overflow

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - Choose the winner among valid ports. If only one port is valid, it wins. If both are valid, the port not in last_grant wins.
  - reqW_ready=1 combinationally for the winner only. On that edge, latch op/x/y/shamt and owner=W, then go to EXEC.
  - If no port is valid, stay in IDLE.
- EXEC:
  - alu_* are driven from the latched operand registers, which stay stable for the whole cycle.
  - On the edge, capture the result register and overflow register, then go to RESP.
  - Supported opcodes: 0010 add, 0110 sub, 0000 and, 0001 or, 1110 shl.
  - Any other opcode captures result=0 and ovf=0, ignoring alu_z and alu_overflow.
- RESP:
  - rspOWNER_valid=1 with the captured z/ovf. The other rspN_valid=0.
  - On rspOWNER_ready=1, set last_grant=owner and go to IDLE.
  - If rspOWNER_ready=0, hold the state and the response indefinitely.
- reqN_ready=0 in EXEC and RESP: only one operation is in flight.
- rspN_z and rspN_ovf of the non-owning port read 0.

## Timing
- Reset (async assert, synchronous-released logic): all of the following take effect immediately on rst_n low.
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - Operand registers=0, so alu_* outputs=0.
  - Result and overflow registers=0, all rspN_valid=0.
  - Any in-flight operation is dropped without a response.
- Latency: accepted at edge k, result captured at edge k+1, rsp_valid high from edge k+1 onward.
  - With rsp_ready held high, the next acceptance is possible at edge k+3.
  - Peak throughput is one operation per 3 cycles.
- Ready is a function of valid and the current state only; it never depends on rsp_ready.
- A request arriving while the arbiter is busy waits. A requester must hold valid and its operands until it sees ready.
- A request that arrives during RESP is granted no earlier than the IDLE cycle that follows the response handshake.
- If the same port requests back to back while the other is valid, the ports alternate.
- A port alone keeps winning, as many times in a row as it requests.

## Configuration
- ALU_ARB_STICKY_OVF_EN defined:
  - Adds output ovf_status (2 bits, one per port) and input ovf_clr (1 bit).
  - ovf_status[N] sets on the RESP handshake of port N when ovf=1.
  - ovf_clr=1 clears both bits on the edge. If set and clear coincide, set wins.
  - ovf_status resets to 00.
- ALU_ARB_STICKY_OVF_EN undefined: the ovf_status and ovf_clr ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then port 0 requests add 0x7FFFFFFF+1 with rsp_ready=1 -> req0_ready in cycle 1; rsp0_valid from edge 2 with z=0x80000000, ovf=1; no ready on port 1.
- Both ports valid from reset (port 0: sub 5-7; port 1: or 0xF0|0x0F) -> grants go 0 then 1; rsp0_z=0xFFFFFFFE, ovf=0; rsp1_z=0x000000FF.
- Hold rsp1_ready=0 for 10 cycles after a shl x=1, shamt=31 -> rsp1_valid and z=0x80000000 stay stable; neither ready asserts until rsp1_ready=1.
- Unsupported op 0101 after a prior add result of 0x1234 -> rsp_z=0, ovf=0.
- Assert rst_n=0 during EXEC -> all rsp_valid=0 immediately; after release, the first tie goes to port 0 and no stale response appears.
- With ALU_ARB_STICKY_OVF_EN: overflowing sub 0x80000000-1 on port 1 -> ovf_status=10 after the handshake; ovf_clr pulse -> 00; clear coincident with a new overflow -> bit remains set.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter that shares one combinational 32-bit ALU between two
// requesters. Each port hands over one operation with a valid/ready handshake.
// The arbiter latches the operands and drives the ALU for one cycle. It then
// captures the result and overflow, and holds them on the owning port's
// response channel until that port accepts them. Only one operation is in
// flight at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake, port N (N = 0, 1)
//   reqN_op/x/y/shamt          request opcode, operands, shift amount
//   rspN_valid/ready           response handshake, port N
//   rspN_z/ovf                 response result and signed-overflow flag
//   alu_op/x/y/shamt           outputs to the shared ALU
//   alu_z/alu_overflow         inputs from the shared ALU
//   ovf_status[1:0], ovf_clr   sticky per-port overflow flags and their clear
//                              (present only with ALU_ARB_STICKY_OVF_EN)
//
// Optional feature macro: ALU_ARB_STICKY_OVF_EN
module alu_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_x,
    input  logic [DW-1:0]  req0_y,
    input  logic [4:0]     req0_shamt,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_x,
    input  logic [DW-1:0]  req1_y,
    input  logic [4:0]     req1_shamt,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_z,
    output logic           rsp0_ovf,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_z,
    output logic           rsp1_ovf,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_x,
    output logic [DW-1:0]  alu_y,
    output logic [4:0]     alu_shamt,
    input  logic [DW-1:0]  alu_z,
    input  logic           alu_overflow
`ifdef ALU_ARB_STICKY_OVF_EN
    ,
    output logic [1:0]     ovf_status,
    input  logic           ovf_clr
`endif
);

    localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);
    localparam logic [OPW-1:0] OP_SHL = OPW'(4'b1110);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic           last_q;     // port granted most recently (reset 1 -> port 0 wins first tie)
    logic           owner_q;    // port whose operation is in flight
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  x_q, y_q;
    logic [4:0]     sh_q;
    logic [DW-1:0]  z_q;
    logic           ovf_q;

    logic any_v, win, accept, rsp_hs, op_ok;

    // Winner: a lone requester always wins; on a tie the port that was not
    // served last wins.
    assign any_v  = req0_valid | req1_valid;
    assign win    = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
    assign accept = (state_q == IDLE) && any_v;
    assign rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

    // Opcodes the ALU does not implement get a defined zero result.
    always_comb begin
        op_ok = 1'b0;
        case (op_q)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHL: op_ok = 1'b1;
            default:                               op_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_v)  state_d = EXEC;
            EXEC:                state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req0_ready = (state_q == IDLE) && req0_valid && !win;
        req1_ready = (state_q == IDLE) && req1_valid &&  win;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) &&  owner_q;
        rsp0_z     = owner_q ? '0 : z_q;
        rsp0_ovf   = owner_q ? 1'b0 : ovf_q;
        rsp1_z     = owner_q ? z_q : '0;
        rsp1_ovf   = owner_q ? ovf_q : 1'b0;
        alu_op     = op_q;
        alu_x      = x_q;
        alu_y      = y_q;
        alu_shamt  = sh_q;
    end

    // Operand, result and grant-history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sh_q    <= '0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                owner_q <= win;
                op_q    <= win ? req1_op    : req0_op;
                x_q     <= win ? req1_x     : req0_x;
                y_q     <= win ? req1_y     : req0_y;
                sh_q    <= win ? req1_shamt : req0_shamt;
            end
            if (state_q == EXEC) begin
                z_q   <= op_ok ? alu_z : '0;
                ovf_q <= op_ok && alu_overflow;
            end
            if (rsp_hs) last_q <= owner_q;
        end
    end

`ifdef ALU_ARB_STICKY_OVF_EN
    // Sticky overflow per port; a set on the same edge as a clear wins.
    logic [1:0] ovf_set;
    assign ovf_set = (rsp_hs && ovf_q) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_status <= 2'b00;
        else        ovf_status <= (ovf_clr ? 2'b00 : ovf_status) | ovf_set;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000,
                           OR_ = 4'b0001, SHL = 4'b1110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        rsp0_valid, rsp0_ready, rsp0_ovf, rsp1_valid, rsp1_ready, rsp1_ovf;
    logic [31:0] rsp0_z, rsp1_z;
    logic [3:0]  alu_op;
    logic [31:0] alu_x, alu_y, alu_z;
    logic [4:0]  alu_shamt;
    logic        alu_overflow;
`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0]  ovf_status;
    logic        ovf_clr;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.DW(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y), .req1_shamt(req1_shamt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z), .rsp0_ovf(rsp0_ovf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z), .rsp1_ovf(rsp1_ovf),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_shamt(alu_shamt),
        .alu_z(alu_z), .alu_overflow(alu_overflow)
`ifdef ALU_ARB_STICKY_OVF_EN
        , .ovf_status(ovf_status), .ovf_clr(ovf_clr)
`endif
    );

    // Reference ALU semantics: exact signed arithmetic, overflow when the true
    // result leaves the 32-bit signed range; unsupported opcodes yield zero.
    localparam longint MAXV = 64'sh7FFF_FFFF;
    localparam longint MINV = -64'sh8000_0000;

    function automatic logic [32:0] ref_alu(logic [3:0] op, logic [31:0] x, logic [31:0] y,
                                            logic [4:0] sh);
        longint s;
        case (op)
            ADD: begin
                s = longint'($signed(x)) + longint'($signed(y));
                return {(s > MAXV) || (s < MINV), s[31:0]};
            end
            SUB: begin
                s = longint'($signed(x)) - longint'($signed(y));
                return {(s > MAXV) || (s < MINV), s[31:0]};
            end
            AND_:    return {1'b0, x & y};
            OR_:     return {1'b0, x | y};
            SHL:     return {1'b0, x << sh};
            default: return 33'b0;
        endcase
    endfunction

    function automatic bit supported(logic [3:0] op);
        return op == ADD || op == SUB || op == AND_ || op == OR_ || op == SHL;
    endfunction

    // Stand-in for the shared ALU; unsupported opcodes produce junk that the
    // arbiter must not forward.
    always_comb begin
        logic [32:0] r;
        r = ref_alu(alu_op, alu_x, alu_y, alu_shamt);
        alu_z        = r[31:0];
        alu_overflow = r[32];
        if (!supported(alu_op)) begin
            alu_z        = alu_x ^ ~alu_y ^ 32'hA5A5_3C3C;
            alu_overflow = 1'b1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] z;
        logic        ovf;
    } exp_t;
    exp_t sbq[$];

    // Transaction-level model: who may be granted, and when a response is due.
    bit m_last, m_busy, m_exec, m_owner;

    // Monitor / scoreboard, sampling at the falling edge.
    initial begin
        logic [1:0]  exp_rv, exp_rdy;
        logic [32:0] r;
        bit          w;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
                chk("rst_alu_x", alu_x, 0);
                chk("rst_alu_op_y_sh", {alu_op, alu_y, alu_shamt}, 0);
                sbq.delete();
                m_last = 1'b1; m_busy = 1'b0; m_exec = 1'b0; m_owner = 1'b0;
            end else begin
                exp_rv = 2'b00;
                if (m_busy && !m_exec) exp_rv[m_owner] = 1'b1;
                chk("rsp_valid", {rsp1_valid, rsp0_valid}, exp_rv);

                exp_rdy = 2'b00;
                w = 1'b0;
                if (!m_busy && (req0_valid || req1_valid)) begin
                    w = (req0_valid && req1_valid) ? !m_last : !req0_valid;
                    exp_rdy[w] = 1'b1;
                end
                chk("req_ready", {req1_ready, req0_ready}, exp_rdy);

                if (exp_rv != 2'b00) begin
                    if (sbq.size() == 0) chk("sb_underflow", 1, 0);
                    else begin
                        e = sbq[0];
                        if (!m_owner) begin
                            chk("rsp0_z", rsp0_z, e.z);
                            chk("rsp0_ovf", rsp0_ovf, e.ovf);
                            chk("rsp1_idle_out", {rsp1_ovf, rsp1_z}, 0);
                        end else begin
                            chk("rsp1_z", rsp1_z, e.z);
                            chk("rsp1_ovf", rsp1_ovf, e.ovf);
                            chk("rsp0_idle_out", {rsp0_ovf, rsp0_z}, 0);
                        end
                    end
                end

                if (exp_rdy != 2'b00) begin
                    r = w ? ref_alu(req1_op, req1_x, req1_y, req1_shamt)
                          : ref_alu(req0_op, req0_x, req0_y, req0_shamt);
                    e.z = r[31:0]; e.ovf = r[32];
                    sbq.push_back(e);
                    m_busy = 1'b1; m_exec = 1'b1; m_owner = w;
                end else if (m_exec) begin
                    m_exec = 1'b0;
                end else if (m_busy && (m_owner ? rsp1_ready : rsp0_ready)) begin
                    if (sbq.size() > 0) void'(sbq.pop_front());
                    m_last = m_owner;
                    m_busy = 1'b0;
                end
            end
        end
    end

    // All drivers run at posedge + 1.
    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue(bit p, logic [3:0] op, logic [31:0] x, logic [31:0] y, logic [4:0] sh);
        int t;
        bit got;
        t = 0; got = 1'b0;
        if (!p) begin
            req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y; req0_shamt = sh;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y; req1_shamt = sh;
        end
        while (!got && t < 200) begin
            @(negedge clk);
            got = p ? req1_ready : req0_ready;
            t++;
        end
        if (!got) chk(p ? "req1_timeout" : "req0_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!p) req0_valid = 1'b0;
        else    req1_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 1));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_port(bit p, int n);
        logic [3:0] ops [5];
        logic [3:0] op;
        ops[0] = ADD; ops[1] = SUB; ops[2] = AND_; ops[3] = OR_; ops[4] = SHL;
        repeat (n) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 4)] : 4'($urandom_range(0, 15));
            issue(p, op, pick_val(), pick_val(), 5'($urandom_range(0, 31)));
        end
    endtask

    bit rand_done;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_x = '0; req0_y = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_op = '0; req1_x = '0; req1_y = '0; req1_shamt = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
`ifdef ALU_ARB_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        do_reset();

        // Port 0 alone: 0x7FFFFFFF + 1 overflows to 0x80000000.
        issue(0, ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        repeat (4) @(posedge clk);
        #1;

        // Tie straight out of reset: port 0 first, then port 1.
        do_reset();
        fork
            issue(0, SUB, 32'd5, 32'd7, 5'd0);
            issue(1, OR_, 32'hF0, 32'h0F, 5'd0);
        join
        repeat (4) @(posedge clk);
        #1;

        // Response held off for 10 cycles while port 0 waits.
        rsp1_ready = 1'b0;
        issue(1, SHL, 32'h1, 32'h0, 5'd31);
        fork
            issue(0, ADD, 32'd3, 32'd4, 5'd0);
            begin
                repeat (10) @(posedge clk);
                #1 rsp1_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Unsupported opcode after a non-zero result.
        issue(0, ADD, 32'h1000, 32'h234, 5'd0);
        issue(0, 4'b0101, 32'h55, 32'h66, 5'd3);
        repeat (4) @(posedge clk);
        #1;

        // Reset while the operation is executing: no stale response after.
        issue(1, ADD, 32'd1, 32'd2, 5'd0);
        do_reset();
        fork
            issue(0, AND_, 32'hFF00, 32'h0FF0, 5'd0);
            issue(1, OR_, 32'h1, 32'h2, 5'd0);
        join
        repeat (4) @(posedge clk);
        #1;

`ifdef ALU_ARB_STICKY_OVF_EN
        do_reset();
        chk("ovf_status_rst", ovf_status, 2'b00);
        issue(1, SUB, 32'h8000_0000, 32'h1, 5'd0);
        repeat (2) @(posedge clk);
        #1 chk("ovf_status_set", ovf_status, 2'b10);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("ovf_status_clr", ovf_status, 2'b00);
        rsp1_ready = 1'b0;
        issue(1, SUB, 32'h8000_0000, 32'h1, 5'd0);
        for (int i = 0; i < 10 && !rsp1_valid; i++) begin
            @(posedge clk);
            #1;
        end
        ovf_clr = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("ovf_status_set_wins", ovf_status, 2'b10);
        repeat (2) @(posedge clk);
        #1;
`endif

        // Randomized traffic on both ports with random response back-pressure.
        rand_done = 1'b0;
        fork
            begin
                fork
                    run_port(0, 60);
                    run_port(1, 60);
                join
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                @(posedge clk);
                #1;
                rsp0_ready = ($urandom_range(0, 3) != 0);
                rsp1_ready = ($urandom_range(0, 3) != 0);
            end
        join
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("sb_drained", 64'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
